// File: rtl/pipe_sequencer.sv
// Pipeline hazard/stall sequencer: load-use bubbles, branch flush, and a data-memory access FSM with timeout.
// Control outputs are combinational from state and inputs; state, counters and error flag are registered.
module pipe_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RS1_i,
  input  logic [4:0]       ID_RS2_i,
  input  logic [4:0]       EX_RD_i,
  input  logic             EX_MemRead_i,
  input  logic             Branch_taken_i,
  input  logic             MEM_MemRead_i,
  input  logic             MEM_MemWrite_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             Stall_o,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             NoOp_o,
  output logic             Flush_o,
  output logic             error_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    ERROR  = 2'b10
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_op;
  logic       hazard;

  always_comb begin
    mem_op = MEM_MemRead_i | MEM_MemWrite_i;
    hazard = EX_MemRead_i && (EX_RD_i != 5'd0) &&
             ((EX_RD_i == ID_RS1_i) || (EX_RD_i == ID_RS2_i));

    // The ack cycle drops the stall so the memory instruction retires on that edge.
    Stall_o = ((state == IDLE) && mem_op) ||
              ((state == ACCESS) && !mem_ack_i) ||
              (state == ERROR);

    PC_Write_o   = 1'b0;
    IFID_Write_o = 1'b0;
    NoOp_o       = 1'b0;
    Flush_o      = 1'b0;
    if (!Stall_o) begin
      if (hazard) begin
        NoOp_o = 1'b1;
      end else begin
        PC_Write_o   = 1'b1;
        IFID_Write_o = 1'b1;
        Flush_o      = Branch_taken_i;
      end
    end
  end

  assign mem_req_o = (state == ACCESS);
  assign state_o   = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      error_o     <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if ((Stall_o || NoOp_o) && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;

      case (state)
        IDLE: begin
          if (mem_op) begin
            state    <= ACCESS;
            wait_cnt <= 8'd0;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= ERROR;
            error_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERROR: begin
          error_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: two instances (default and TIMEOUT=4/CNT_W=2) on shared inputs,
// checked every cycle against an abstract model, plus directed scenarios with fixed expectations.
module tb_pipe_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] ID_RS1_i, ID_RS2_i, EX_RD_i;
  logic       EX_MemRead_i, Branch_taken_i, MEM_MemRead_i, MEM_MemWrite_i, mem_ack_i;

  logic        o0_req, o0_stall, o0_pcw, o0_ifw, o0_noop, o0_flush, o0_err;
  logic [1:0]  o0_state;
  logic [15:0] o0_cnt;
  logic        o1_req, o1_stall, o1_pcw, o1_ifw, o1_noop, o1_flush, o1_err;
  logic [1:0]  o1_state;
  logic [1:0]  o1_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Abstract model state per instance
  bit m_acc[2];
  bit m_err[2];
  int m_elapsed[2];
  int m_cnt[2];
  int tmo[2]  = '{16, 4};
  int cmax[2] = '{65535, 3};

  always #5 clk_i = ~clk_i;

  pipe_sequencer #(.TIMEOUT(16), .CNT_W(16)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .ID_RS1_i(ID_RS1_i), .ID_RS2_i(ID_RS2_i), .EX_RD_i(EX_RD_i),
    .EX_MemRead_i(EX_MemRead_i), .Branch_taken_i(Branch_taken_i), .MEM_MemRead_i(MEM_MemRead_i),
    .MEM_MemWrite_i(MEM_MemWrite_i), .mem_ack_i(mem_ack_i), .mem_req_o(o0_req), .Stall_o(o0_stall),
    .PC_Write_o(o0_pcw), .IFID_Write_o(o0_ifw), .NoOp_o(o0_noop), .Flush_o(o0_flush),
    .error_o(o0_err), .state_o(o0_state), .stall_cnt_o(o0_cnt));

  pipe_sequencer #(.TIMEOUT(4), .CNT_W(2)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .ID_RS1_i(ID_RS1_i), .ID_RS2_i(ID_RS2_i), .EX_RD_i(EX_RD_i),
    .EX_MemRead_i(EX_MemRead_i), .Branch_taken_i(Branch_taken_i), .MEM_MemRead_i(MEM_MemRead_i),
    .MEM_MemWrite_i(MEM_MemWrite_i), .mem_ack_i(mem_ack_i), .mem_req_o(o1_req), .Stall_o(o1_stall),
    .PC_Write_o(o1_pcw), .IFID_Write_o(o1_ifw), .NoOp_o(o1_noop), .Flush_o(o1_flush),
    .error_o(o1_err), .state_o(o1_state), .stall_cnt_o(o1_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit f_hazard();
    return EX_MemRead_i && (EX_RD_i != 5'd0) && ((EX_RD_i == ID_RS1_i) || (EX_RD_i == ID_RS2_i));
  endfunction

  function automatic bit f_stall(int i);
    bit mem_op = MEM_MemRead_i | MEM_MemWrite_i;
    if (m_err[i]) return 1'b1;
    if (m_acc[i]) return !mem_ack_i;
    return mem_op;
  endfunction

  task automatic compare_inst(input int i, input logic req, input logic stall, input logic pcw,
                              input logic ifw, input logic noop, input logic flush, input logic err,
                              input logic [1:0] st, input logic [31:0] cnt);
    bit s = f_stall(i);
    bit h = f_hazard();
    string p = (i == 0) ? "d0" : "d1";
    check({p, ".req"},   req,   m_acc[i]);
    check({p, ".stall"}, stall, s);
    check({p, ".pcw"},   pcw,   !s && !h);
    check({p, ".ifw"},   ifw,   !s && !h);
    check({p, ".noop"},  noop,  !s && h);
    check({p, ".flush"}, flush, !s && !h && Branch_taken_i);
    check({p, ".err"},   err,   m_err[i]);
    check({p, ".state"}, st,    m_err[i] ? 2 : (m_acc[i] ? 1 : 0));
    check({p, ".cnt"},   cnt,   m_cnt[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_err[i] = 0; m_elapsed[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit s = f_stall(i);
      bit busy = s || f_hazard();
      if (rst_i) begin
        m_acc[i] = 0; m_err[i] = 0; m_elapsed[i] = 0; m_cnt[i] = 0;
      end else begin
        if (busy && m_cnt[i] < cmax[i]) m_cnt[i]++;
        if (m_err[i]) begin
        end else if (m_acc[i]) begin
          if (mem_ack_i) m_acc[i] = 0;
          else begin
            m_elapsed[i]++;
            if (m_elapsed[i] == tmo[i]) begin
              m_acc[i] = 0; m_err[i] = 1;
            end
          end
        end else if (MEM_MemRead_i | MEM_MemWrite_i) begin
          m_acc[i] = 1; m_elapsed[i] = 0;
        end
      end
    end
  endtask

  // Called at posedge+1 with inputs applied; checks at negedge, advances model at the next edge.
  task automatic step();
    @(negedge clk_i);
    compare_inst(0, o0_req, o0_stall, o0_pcw, o0_ifw, o0_noop, o0_flush, o0_err, o0_state, 32'(o0_cnt));
    compare_inst(1, o1_req, o1_stall, o1_pcw, o1_ifw, o1_noop, o1_flush, o1_err, o1_state, 32'(o1_cnt));
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic quiet_inputs();
    ID_RS1_i = 0; ID_RS2_i = 0; EX_RD_i = 0; EX_MemRead_i = 0; Branch_taken_i = 0;
    MEM_MemRead_i = 0; MEM_MemWrite_i = 0; mem_ack_i = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_i = 1; step();
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1;
    quiet_inputs();
    @(posedge clk_i); #1;
    model_reset();
    rst_i = 0;
    #1;
    check("rst.state", o0_state, 2'd0);
    check("rst.req",   o0_req,   1'b0);
    check("rst.err",   o0_err,   1'b0);
    check("rst.cnt",   o0_cnt,   16'd0);

    // Load in MEM, ack on the third ACCESS cycle
    MEM_MemRead_i = 1; step();
    step();
    step();
    mem_ack_i = 1; #1;
    check("ld.ack_stall", o0_stall, 1'b0);
    check("ld.ack_req",   o0_req,   1'b1);
    step();
    quiet_inputs(); #1;
    check("ld.state", o0_state, 2'd0);
    check("ld.cnt",   o0_cnt,   16'd3);
    step();

    // Load-use bubble, then rd=x0 gives no bubble
    do_reset();
    EX_MemRead_i = 1; EX_RD_i = 5; ID_RS2_i = 5; #1;
    check("lu.noop", o0_noop, 1'b1);
    check("lu.pcw",  o0_pcw,  1'b0);
    check("lu.ifw",  o0_ifw,  1'b0);
    step();
    EX_RD_i = 0; ID_RS2_i = 0; #1;
    check("x0.noop", o0_noop, 1'b0);
    check("x0.pcw",  o0_pcw,  1'b1);
    step();

    // Hazard suppresses flush; flush appears once hazard clears
    EX_RD_i = 7; ID_RS1_i = 7; Branch_taken_i = 1; #1;
    check("hb.flush", o0_flush, 1'b0);
    step();
    EX_MemRead_i = 0; #1;
    check("br.flush", o0_flush, 1'b1);
    step();

    // Timeout on the TIMEOUT=4 instance
    do_reset();
    MEM_MemWrite_i = 1;
    repeat (5) step();
    check("to.state", o1_state, 2'd2);
    check("to.err",   o1_err,   1'b1);
    check("to.stall", o1_stall, 1'b1);
    check("to.d0st",  o0_state, 2'd1);
    do_reset();
    check("to.rst_state", o1_state, 2'd0);
    check("to.rst_err",   o1_err,   1'b0);
    check("to.rst_req",   o1_req,   1'b0);

    // mem_op + hazard + branch: stall wins; counter saturation on narrow instance
    MEM_MemRead_i = 1; EX_MemRead_i = 1; EX_RD_i = 3; ID_RS1_i = 3; Branch_taken_i = 1; #1;
    check("all.stall", o0_stall, 1'b1);
    check("all.noop",  o0_noop,  1'b0);
    check("all.flush", o0_flush, 1'b0);
    repeat (5) step();
    check("sat.d1cnt", o1_cnt, 2'd3);
    check("sat.d0cnt", o0_cnt, 16'd5);

    // Randomised traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_i          = ($urandom_range(0, 59) == 0) || (m_err[0] && $urandom_range(0, 3) == 0);
      ID_RS1_i       = 5'($urandom_range(0, 3));
      ID_RS2_i       = 5'($urandom_range(0, 3));
      EX_RD_i        = 5'($urandom_range(0, 3));
      EX_MemRead_i   = ($urandom_range(0, 1) == 0);
      Branch_taken_i = ($urandom_range(0, 2) == 0);
      MEM_MemRead_i  = ($urandom_range(0, 3) == 0);
      MEM_MemWrite_i = ($urandom_range(0, 4) == 0);
      mem_ack_i      = ($urandom_range(0, 3) == 0);
      step();
    end
    rst_i = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 16, max ACCESS cycles without mem_ack_i before ERROR (range 1..255).
REQ-002 Parameter: CNT_W, 16, width of stall-cycle performance counter.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 ID_RS1_i  in  5  rs1 of instruction in ID.
REQ-006 ID_RS2_i  in  5  rs2 of instruction in ID.
REQ-007 EX_RD_i  in  5  rd of instruction in EX.
REQ-008 EX_MemRead_i  in  1  instruction in EX is a load.
REQ-009 Branch_taken_i  in  1  branch in ID resolved taken.
REQ-010 MEM_MemRead_i  in  1  instruction in MEM is a load.
REQ-011 MEM_MemWrite_i  in  1  instruction in MEM is a store.
REQ-012 mem_ack_i  in  1  data memory completes the current access.
REQ-013 mem_req_o  out  1  data memory access request.
REQ-014 Stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-015 PC_Write_o  out  1  PC update enable.
REQ-016 IFID_Write_o  out  1  IF/ID update enable.
REQ-017 NoOp_o  out  1  drives Control NoOp_i (bubble into ID/EX).
REQ-018 Flush_o  out  1  clear IF/ID (taken branch).
REQ-019 error_o  out  1  sticky memory-timeout flag.
REQ-020 state_o  out  2  FSM state: 00 IDLE, 01 ACCESS, 10 ERROR.
REQ-021 stall_cnt_o  out  CNT_W  saturating count of frozen/bubble cycles.

Function
REQ-022 mem_op = MEM_MemRead_i | MEM_MemWrite_i; hazard = EX_MemRead_i & (EX_RD_i != 0) & (EX_RD_i == ID_RS1_i | EX_RD_i == ID_RS2_i).
REQ-023 FSM IDLE: mem_op -> ACCESS next edge, else stay; mem_ack_i ignored in IDLE.
REQ-024 FSM ACCESS: mem_ack_i=1 -> IDLE next edge; else wait counter increments; mem_ack_i=0 with counter == TIMEOUT-1 -> ERROR.
REQ-025 Wait counter cleared on every IDLE->ACCESS entry; ack is accepted on ACCESS cycles 1..TIMEOUT; TIMEOUT cycles without ack -> ERROR.
REQ-026 FSM ERROR: absorbing; left only by rst_i; error_o=1 in ERROR.
REQ-027 mem_req_o = 1 exactly when state is ACCESS (Moore, no input dependence).
REQ-028 Stall_o = (IDLE & mem_op) | (ACCESS & ~mem_ack_i) | ERROR; ack cycle releases stall so the memory instruction retires at that edge.
REQ-029 Back-to-back memory ops: after ack, FSM returns to IDLE; next mem_op re-enters ACCESS with one IDLE stall cycle between.
REQ-030 Stall_o=1: PC_Write_o=0, IFID_Write_o=0, NoOp_o=0, Flush_o=0 (stall has priority over hazard and branch).
REQ-031 Stall_o=0, hazard=1: PC_Write_o=0, IFID_Write_o=0, NoOp_o=1, Flush_o=0 (branch flush suppressed; branch re-evaluated next cycle).
REQ-032 Stall_o=0, hazard=0: PC_Write_o=1, IFID_Write_o=1, NoOp_o=0, Flush_o=Branch_taken_i.
REQ-033 rd=x0 never causes hazard.
REQ-034 stall_cnt_o increments by 1 each cycle Stall_o|NoOp_o is 1; saturates at all-ones, no wrap.
REQ-035 Control outputs combinational from state and inputs; state, counters, error_o registered.

Reset
REQ-036 rst_i=1 at an edge: state IDLE, wait counter 0, stall_cnt_o 0, error_o 0; next cycle mem_req_o=0.
REQ-037 Reset mid-ACCESS or in ERROR: abandon access, mem_req_o drops after that edge, pending ack ignored.
REQ-038 Reset has priority over all transitions and counter updates in the same cycle.

Verification
REQ-039 Load in MEM, ack on 3rd ACCESS cycle -> Stall_o=1 for 3 cycles, mem_req_o=1 for 3 cycles, state 00->01->00, stall_cnt_o=3.
REQ-040 EX lw rd=5, ID rs2=5, no mem_op -> NoOp_o=1, PC_Write_o=0, IFID_Write_o=0 one cycle; rd=0 same pattern -> no bubble.
REQ-041 Hazard and Branch_taken_i same cycle -> Flush_o=0; next cycle hazard clear -> Flush_o=1.
REQ-042 TIMEOUT=4, no ack -> ERROR after 4 ACCESS cycles, error_o=1, Stall_o stuck 1; rst_i -> all cleared.
REQ-043 Mem_op plus hazard plus taken branch together -> Stall_o=1, NoOp_o=0, Flush_o=0.
REQ-044 CNT_W=2, 5 stall cycles -> stall_cnt_o saturates at 3.
